// File: rtl/exec_pkg.sv
//==============================================================================
// Module      : exec_pkg
// Description : Shared funct codes, ALU control encodings and funct decoder
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package exec_pkg;

    localparam logic [5:0] c_FUNCT_AND = 6'b100100;
    localparam logic [5:0] c_FUNCT_OR  = 6'b100101;
    localparam logic [5:0] c_FUNCT_ADD = 6'b100000;
    localparam logic [5:0] c_FUNCT_SUB = 6'b100010;
    localparam logic [5:0] c_FUNCT_SLT = 6'b101010;

    typedef enum logic [2:0] {
        c_ALU_AND = 3'b000,
        c_ALU_OR  = 3'b001,
        c_ALU_ADD = 3'b010,
        c_ALU_SUB = 3'b110,
        c_ALU_SLT = 3'b111
    } alu_op_e;

    typedef struct packed {
        alu_op_e f;
        logic    err;
    } dec_t;

    function automatic dec_t decode_funct(input logic [5:0] funct);
        dec_t d;
        d.f   = c_ALU_AND;
        d.err = 1'b0;
        case (funct)
            c_FUNCT_AND: d.f = c_ALU_AND;
            c_FUNCT_OR:  d.f = c_ALU_OR;
            c_FUNCT_ADD: d.f = c_ALU_ADD;
            c_FUNCT_SUB: d.f = c_ALU_SUB;
            c_FUNCT_SLT: d.f = c_ALU_SLT;
            default:     d.err = 1'b1;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
//==============================================================================
// Module      : alu
// Description : Combinational AND/OR/ADD/SUB/SLT unit
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          f,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] w_diff;

    assign w_diff = a - b;

    // SLT takes the raw sign of a-b; overflow is deliberately not corrected
    always_comb begin
        y = '0;
        case (f)
            c_ALU_AND: y = a & b;
            c_ALU_OR:  y = a | b;
            c_ALU_ADD: y = a + b;
            c_ALU_SUB: y = w_diff;
            c_ALU_SLT: y = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1]};
            default:   y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/exec_stage.sv
//==============================================================================
// Module      : exec_stage
// Description : Two-stage R-type execute slice with 32x32 register file,
//               result forwarding and an external register-load port
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module exec_stage
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic [4:0]       out_rd,
    output logic             out_err,
    input  logic             ld_en,
    input  logic [4:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data
);

    logic                   r_s1_full;
    logic [4:0]             r_s1_rs;
    logic [4:0]             r_s1_rt;
    logic [4:0]             r_s1_rd;
    alu_op_e                r_s1_f;
    logic                   r_s1_err;

    logic                   r_s2_full;
    logic [WIDTH-1:0]       r_y;
    logic                   r_zero;
    logic [4:0]             r_rd;
    logic                   r_err;

    logic [WIDTH-1:0]       r_rf [32];

    logic                   w_accept;
    logic                   w_s1_adv;
    logic                   w_s2_hs;
    logic                   w_wb;
    dec_t                   w_dec;
    logic [1:0][4:0]        w_src;
    logic [1:0][WIDTH-1:0]  w_opnd;
    logic [WIDTH-1:0]       w_alu_y;
    logic [WIDTH-1:0]       w_result;

    assign w_s2_hs  = r_s2_full & out_ready;
    assign w_s1_adv = r_s1_full & (~r_s2_full | w_s2_hs);
    assign in_ready = ~r_s1_full | w_s1_adv;
    assign w_accept = in_valid & in_ready;
    assign w_wb     = w_s2_hs & ~r_err;
    assign w_dec    = decode_funct(in_funct);

    assign out_valid = r_s2_full;
    assign out_y     = r_y;
    assign out_zero  = r_zero;
    assign out_rd    = r_rd;
    assign out_err   = r_err;

    assign w_src[0] = r_s1_rs;
    assign w_src[1] = r_s1_rt;

    // Operand select: S2 result first, then a same-edge load, then the array
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
        assign w_opnd[gi] =
            (r_s2_full && !r_err && (r_rd == w_src[gi]) && (w_src[gi] != 5'd0)) ? r_y :
            (ld_en && (ld_addr == w_src[gi]) && (w_src[gi] != 5'd0))           ? ld_data :
                                                                                 r_rf[w_src[gi]];
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a (w_opnd[0]),
        .b (w_opnd[1]),
        .f (r_s1_f),
        .y (w_alu_y)
    );

    assign w_result = r_s1_err ? '0 : w_alu_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_full <= 1'b0;
            r_s1_rs   <= '0;
            r_s1_rt   <= '0;
            r_s1_rd   <= '0;
            r_s1_f    <= c_ALU_AND;
            r_s1_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_full <= 1'b1;
                r_s1_rs   <= in_rs;
                r_s1_rt   <= in_rt;
                r_s1_rd   <= in_rd;
                r_s1_f    <= w_dec.f;
                r_s1_err  <= w_dec.err;
            end else if (w_s1_adv) begin
                r_s1_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_full <= 1'b0;
            r_y       <= '0;
            r_zero    <= 1'b0;
            r_rd      <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s2_full <= 1'b1;
                r_y       <= w_result;
                r_zero    <= (w_result == '0);
                r_rd      <= r_s1_rd;
                r_err     <= r_s1_err;
            end else if (w_s2_hs) begin
                r_s2_full <= 1'b0;
            end
        end
    end

    // r0 is never written; writeback beats a load to the same register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_wb && (r_rd == 5'(i))) begin
                    r_rf[i] <= r_y;
                end else if (ld_en && (ld_addr == 5'(i))) begin
                    r_rf[i] <= ld_data;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exec_stage.sv
//==============================================================================
// Module      : tb_exec_stage
// Description : Self-checking bench for exec_stage against an in-order ISA model
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_exec_stage;

    localparam logic [5:0] c_AND = 6'b100100;
    localparam logic [5:0] c_OR  = 6'b100101;
    localparam logic [5:0] c_ADD = 6'b100000;
    localparam logic [5:0] c_SUB = 6'b100010;
    localparam logic [5:0] c_SLT = 6'b101010;

    typedef struct {
        logic [5:0] funct;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } instr_t;

    typedef struct {
        logic [31:0] y;
        logic [4:0]  rd;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_funct;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        out_zero;
    logic [4:0]  out_rd;
    logic        out_err;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;

    instr_t      pend[$];
    res_t        expq[$];
    logic [31:0] mrf [32];
    int          passed = 0;
    int          total  = 0;
    logic        gaps   = 1'b0;

    exec_stage #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_funct  (in_funct),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_rd    (out_rd),
        .out_err   (out_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Sequential ISA semantics: each accepted instruction executes completely, in order
    task automatic model_accept(input instr_t ins);
        res_t        r;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        a = mrf[ins.rs];
        b = mrf[ins.rt];
        d = a - b;
        r.rd  = ins.rd;
        r.err = 1'b0;
        case (ins.funct)
            c_AND:   r.y = a & b;
            c_OR:    r.y = a | b;
            c_ADD:   r.y = a + b;
            c_SUB:   r.y = d;
            c_SLT:   r.y = {31'd0, d[31]};
            default: begin r.y = 32'd0; r.err = 1'b1; end
        endcase
        if (!r.err && ins.rd != 5'd0) mrf[ins.rd] = r.y;
        expq.push_back(r);
    endtask

    task automatic drive();
        in_valid = (pend.size() != 0) && !(gaps && ($urandom_range(0, 2) == 0));
        if (pend.size() != 0) begin
            in_funct = pend[0].funct;
            in_rs    = pend[0].rs;
            in_rt    = pend[0].rt;
            in_rd    = pend[0].rd;
        end else begin
            in_funct = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        end
    endtask

    task automatic tick();
        logic acc;
        logic hs;
        res_t e;
        #1;
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        if (hs) begin
            if (expq.size() == 0) begin
                chk("spurious_output", {31'd0, out_valid}, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("out_y",    out_y,              e.y);
                chk("out_rd",   {27'd0, out_rd},    {27'd0, e.rd});
                chk("out_err",  {31'd0, out_err},   {31'd0, e.err});
                chk("out_zero", {31'd0, out_zero},  {31'd0, (e.y == 32'd0)});
            end
        end
        if (acc) model_accept(pend.pop_front());
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_all(input int budget);
        int n = 0;
        while ((pend.size() != 0 || expq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", pend.size() + expq.size(), 32'd0);
    endtask

    task automatic ld_reg(input logic [4:0] addr, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        if (addr != 5'd0) mrf[addr] = data;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic push(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        instr_t i;
        i.funct = f; i.rs = rs; i.rt = rt; i.rd = rd;
        pend.push_back(i);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_funct = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        out_ready = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_y",     out_y,              32'd0);
        chk("rst_out_zero",  {31'd0, out_zero},  32'd0);
        chk("rst_out_err",   {31'd0, out_err},   32'd0);
        chk("rst_out_rd",    {27'd0, out_rd},    32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // ADD with 2-cycle latency and writeback
        ld_reg(5'd1, 32'd5);
        ld_reg(5'd2, 32'd7);
        out_ready = 1'b1;
        push(c_ADD, 5'd1, 5'd2, 5'd3);
        drive();
        tick();
        chk("lat_not_yet_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("add_y",     out_y,              32'd12);
        chk("add_zero",  {31'd0, out_zero},  32'd0);
        run_all(10);
        push(c_OR, 5'd3, 5'd3, 5'd0);
        drive();
        run_all(10);

        // SUB / SLT corner values
        push(c_SUB, 5'd1, 5'd2, 5'd8);
        push(c_SLT, 5'd1, 5'd2, 5'd9);
        push(c_SLT, 5'd2, 5'd1, 5'd10);
        drive();
        run_all(20);

        // Back-to-back dependency through forwarding, no stall
        push(c_ADD, 5'd1, 5'd2, 5'd3);
        push(c_ADD, 5'd3, 5'd1, 5'd4);
        drive();
        tick();
        #1 chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("b2b_first_y", out_y, 32'd12);
        tick();
        chk("b2b_second_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_second_y",     out_y,              32'd17);
        run_all(10);

        // Backpressure: two accepted, third blocked, outputs held
        out_ready = 1'b0;
        push(c_ADD, 5'd1, 5'd2, 5'd11);
        push(c_SUB, 5'd2, 5'd1, 5'd12);
        push(c_OR,  5'd1, 5'd2, 5'd13);
        drive();
        tick();
        tick();
        #1;
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_accepted", pend.size(),       32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_y",     out_y,              expq[0].y);
            chk("bp_hold_rd",    {27'd0, out_rd},    {27'd0, expq[0].rd});
        end
        out_ready = 1'b1;
        run_all(20);

        // Illegal funct leaves destination untouched; r0 stays zero
        ld_reg(5'd5, 32'd99);
        push(6'b000000, 5'd1, 5'd2, 5'd5);
        push(c_ADD, 5'd1, 5'd2, 5'd0);
        push(c_OR,  5'd5, 5'd5, 5'd0);
        push(c_OR,  5'd0, 5'd0, 5'd0);
        drive();
        run_all(20);

        // Writeback wins over a same-edge load to the same register
        push(c_ADD, 5'd1, 5'd2, 5'd7);
        drive();
        tick();
        tick();
        ld_en = 1'b1; ld_addr = 5'd7; ld_data = 32'hDEAD_BEEF;
        tick();
        ld_en = 1'b0;
        push(c_OR, 5'd7, 5'd7, 5'd0);
        drive();
        run_all(10);

        // A load on the advance edge is seen by the advancing instruction
        mrf[6] = 32'd21;
        push(c_ADD, 5'd6, 5'd6, 5'd14);
        drive();
        tick();
        ld_en = 1'b1; ld_addr = 5'd6; ld_data = 32'd21;
        tick();
        ld_en = 1'b0;
        run_all(10);

        // Randomized traffic with valid gaps and random backpressure
        for (int i = 1; i < 8; i++) ld_reg(5'(i), $urandom);
        for (int i = 0; i < 60; i++) begin
            logic [5:0] f;
            case ($urandom_range(0, 5))
                0: f = c_AND;
                1: f = c_OR;
                2: f = c_ADD;
                3: f = c_SUB;
                4: f = c_SLT;
                default: f = 6'($urandom_range(0, 15));
            endcase
            push(f, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        gaps = 1'b1;
        drive();
        begin
            int n = 0;
            while ((pend.size() != 0 || expq.size() != 0) && n < 2000) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
                n++;
            end
        end
        gaps = 1'b0;
        out_ready = 1'b1;
        chk("rand_drain", pend.size() + expq.size(), 32'd0);
        for (int i = 1; i < 8; i++) push(c_OR, 5'(i), 5'(i), 5'd0);
        drive();
        run_all(30);

        // Reset with both stages full drops everything
        out_ready = 1'b0;
        push(c_ADD, 5'd1, 5'd2, 5'd3);
        push(c_ADD, 5'd3, 5'd3, 5'd4);
        drive();
        tick();
        tick();
        chk("full_before_reset", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_y",     out_y,              32'd0);
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        pend.delete();
        expq.delete();
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #3 reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) push(c_OR, 5'(i), 5'(i), 5'd0);
        drive();
        run_all(200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  instruction offered.
REQ-005 SHALL have port in_ready  output  1  instruction accepted when in_valid&in_ready.
REQ-006 SHALL have port in_funct  input  6  R-type funct field.
REQ-007 SHALL have ports in_rs, in_rt, in_rd  input  5 each  source and destination register indices.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  result consumed when out_valid&out_ready.
REQ-010 SHALL have ports out_y (output, 32, result), out_zero (output, 1, out_y==0), out_rd (output, 5, destination), out_err (output, 1, illegal funct).
REQ-011 SHALL have ports ld_en (input, 1), ld_addr (input, 5) and ld_data (input, 32), forming an external register-load port.

Function
REQ-012 SHALL contain a 32x32 register file; r0 SHALL read 0, and writes to r0 SHALL be discarded.
REQ-013 SHALL decode funct to ALU control f: 100100 AND->000, 100101 OR->001, 100000 ADD->010, 100010 SUB->110, 101010 SLT->111.
- Any other funct SHALL be treated as illegal.
REQ-014 SHALL implement two stages: S1 (decode/hold) and S2 (output register).
- Each stage SHALL have a full flag.
REQ-015 An accepted instruction SHALL enter S1 on the accepting edge.
- S1 SHALL advance to S2 on an edge where S2 is empty or S2 is handshaking.
REQ-016 in_ready SHALL equal !s1_full | s1_advance, giving 1 instruction/cycle throughput with no bubbles under continuous out_ready.
REQ-017 Operands SHALL be read at S1->S2 advance, with this priority:
- S2 result, if S2 is full, non-err, out_rd==src and src!=0;
- else the same-cycle ld write, if addresses match;
- else the register file.
REQ-018 SLT SHALL return 1 when the sign bit of a-b is 1, else 0, with no overflow correction.
- ADD and SUB SHALL wrap modulo 2^32.
REQ-019 out_y, out_rd, out_err and out_zero SHALL be registered and SHALL remain stable while out_valid&!out_ready.
REQ-020 An illegal funct SHALL produce out_err=1, out_y=0 and out_zero=1, and SHALL NOT be written back.
REQ-021 On each output handshake with out_err=0, the block SHALL write out_y into rf[out_rd].
REQ-022 ld_en SHALL write ld_data into rf[ld_addr] at any time.
- If ld_en and writeback target the same register on the same edge, the writeback SHALL win.
REQ-023 Minimum latency SHALL be 2 cycles: accepted at edge N gives out_valid high after edge N+1.

Reset
REQ-024 Reset SHALL asynchronously clear s1_full and s2_full.
- out_valid, out_y, out_zero, out_err and out_rd SHALL all be 0 while reset is high.
- in_ready SHALL be 1 while reset is high.
REQ-025 Reset SHALL clear all 32 registers to 0.
REQ-026 Reset mid-operation SHALL drop in-flight instructions without writeback.

Structure
REQ-027 Funct codes and ALU f encodings SHALL live in a shared package exec_pkg.
REQ-028 The ALU operation SHALL be a single instantiated sub-module, alu (ports a, b, f, y).
- out_zero SHALL be derived in exec_stage.

Verification
REQ-029 Bench SHALL cover: ld r1=5, r2=7; ADD rd=3 -> out_y=12, out_zero=0 two cycles after acceptance; rf[3]=12 after handshake.
REQ-030 Bench SHALL cover: SUB r1-r2 with r1=5, r2=7 -> out_y=0xFFFFFFFE; SLT same operands -> out_y=1; SLT r2,r1 -> 0, out_zero=1.
REQ-031 Bench SHALL cover back-to-back dependency: ADD r3=r1+r2 then ADD r4=r3+r1 -> second out_y=17 with no stall.
REQ-032 Bench SHALL cover backpressure: out_ready=0 for 5 cycles with 3 offered instructions -> in_ready=0 after two accepted, outputs held stable, all three results in order after release.
REQ-033 Bench SHALL cover: funct 000000 -> out_err=1, out_y=0, destination unchanged; write to rd=0 -> r0 still reads 0.
REQ-034 Bench SHALL cover: reset asserted while both stages are full -> out_valid=0 immediately, all registers read 0 afterwards.
